gc_engine: RTL and testbench
============================

Name: gc_engine

Overview:
- Parametrised garbage-collection engine for the NVM flash translation layer; successor to the fixed-size GC state definition.
- Selects a victim block by the lowest valid-page count, issues COPY commands for its valid pages, then one ERASE command to the flash controller.
- Yields to host traffic and resumes afterwards.
- Sits between the FTL metadata tables (valid-count table, page-valid bitmap) and the flash command queue.

Parameters:
BLOCK_W  10  block address width; BLOCK_NUM = 2**BLOCK_W
PAGE_W  6  page-in-block width; PAGE_NUM = 2**PAGE_W
GC_THRESHOLD  16  GC triggers when free_blocks < GC_THRESHOLD

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
free_blocks  in  BLOCK_W+1  current free-block count
force_gc  in  1  start GC regardless of threshold; sampled in IDLE only
host_req  in  1  host activity pending; GC must yield
vc_addr  out  BLOCK_W  valid-count table read address
vc_count  in  PAGE_W+1  valid-page count of the block at vc_addr, one cycle after the address
vc_free  in  1  block is erased/free, same timing as vc_count
pv_block  out  BLOCK_W  page-valid bitmap read, block
pv_page  out  PAGE_W  page-valid bitmap read, page
pv_valid  in  1  page valid, one cycle after the address
cmd_valid  out  1  command valid
cmd_ready  in  1  flash controller accepts the command
cmd_op  out  2  01 = COPY, 10 = ERASE, 00 = none
cmd_block  out  BLOCK_W  source/erase block
cmd_page  out  PAGE_W  source page (0 for ERASE)
gc_busy  out  1  high in any state other than IDLE
gc_done  out  1  one-cycle pulse after ERASE is accepted
gc_fail  out  1  one-cycle pulse when no reclaimable victim exists
victim  out  BLOCK_W  victim block of the current/last run

Behaviour:
- Reset: state IDLE. All outputs 0. Internal best count = PAGE_NUM+1; scan/page indices 0.
- IDLE -> INI when (free_blocks < GC_THRESHOLD or force_gc) and !host_req.
- INI (scan):
  - vc_addr steps 0..BLOCK_NUM-1, one per cycle; data is compared one cycle later.
  - Blocks with vc_free=1 are skipped.
  - A candidate replaces the best only if its count is strictly less, so the lowest index wins ties.
  - The scan takes BLOCK_NUM+1 cycles, then goes to INI_DONE.
- INI_DONE:
  - If best count >= PAGE_NUM (no block reclaimable, or all blocks free): pulse gc_fail, go to IDLE.
  - Else latch victim and go to MOVE_START with page 0.
- MOVE_START:
  - Drive pv_block = victim, pv_page = page index. Check pv_valid one cycle later.
  - If valid: assert cmd_valid with COPY (victim, page) and hold all cmd fields stable until cmd_valid & cmd_ready.
  - If invalid: skip the page.
  - After page PAGE_NUM-1, go to ERASE.
  - Wrap-around: the page counter must not wrap back to 0 and reissue copies.
- ERASE: cmd_valid with ERASE (victim, 0) until accepted, then FINISH.
- FINISH: pulse gc_done for one cycle, then IDLE. The next run requires a fresh trigger evaluation in IDLE.
- INTERRUPT:
  - Entered from INI or MOVE_START when host_req=1 and no command is outstanding.
  - A pending cmd_valid is never dropped; the engine waits for acceptance first.
  - While host_req=1: hold, gc_busy=1, cmd_valid=0.
  - On host_req=0: return to INI restarting at block 0 with the best count reset, or to MOVE_START at the saved page.
  - ERASE is never interrupted.
- Simultaneous events:
  - host_req and cmd_ready in the same cycle: the handshake completes, then INTERRUPT.
  - force_gc outside IDLE is ignored.
- RST at any cycle aborts the run. No command is reissued; vc/pv reads stop immediately.
- Width rules:
  - vc_count is PAGE_W+1 wide so PAGE_NUM is representable.
  - free_blocks is compared unsigned.

Optional Feature:
- Macro GC_STATS_EN.
- When defined, adds outputs:
  - stat_runs (16 bits): counts gc_done pulses.
  - stat_moves (24 bits): counts accepted COPY commands.
  - Both saturate at all-ones and reset to 0 on RST.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package nvm_pkg holds:
  - BLOCK_W, PAGE_W, BLOCK_NUM, PAGE_NUM, GC_THRESHOLD
  - block_t, page_t
  - gc_state_t, extended with ERASE; the INI_DONE encoding is 4'd3
  - cmd_op_t (NONE=2'b00, COPY=2'b01, ERASE=2'b10)
- One natural sub-module, gc_victim_scan: the pipelined min-search with skip and tie rules. It exposes start, restart, done, best_block, best_count.

Test Plan:
- BLOCK_W=3, PAGE_W=2; counts {4,2,3,2,4,1(free),4,3}, free_blocks=1 -> victim=1; COPY for valid pages {0,3} only; ERASE block 1; gc_done one cycle after ERASE accepted.
- All blocks count=PAGE_NUM=4, force_gc=1 -> scan completes, gc_fail pulses once, no cmd_valid ever asserted.
- cmd_ready held low 5 cycles during a COPY -> cmd_valid/op/block/page stable all 5 cycles; exactly one COPY accepted.
- host_req raised mid-scan at block 4 -> INTERRUPT, cmd_valid=0; on release the scan restarts at 0 and the correct victim is found.
- host_req raised while COPY page 1 is pending and cmd_ready=1 in the same cycle -> COPY accepted, INTERRUPT; on resume, page 2 is read next with no duplicate COPY.
- RST asserted during ERASE wait -> next cycle all outputs 0, state IDLE. With GC_STATS_EN: stat_runs=1 and stat_moves=2 after the first scenario.

Source files
------------

// File: rtl/nvm_pkg.sv
// Shared FTL garbage-collection types and default geometry.
package nvm_pkg;

  localparam int BLOCK_W      = 10;
  localparam int PAGE_W       = 6;
  localparam int BLOCK_NUM    = 2**BLOCK_W;
  localparam int PAGE_NUM     = 2**PAGE_W;
  localparam int GC_THRESHOLD = 16;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [PAGE_W-1:0]  page_t;

  typedef enum logic [3:0] {
    GC_IDLE       = 4'd0,
    GC_INI        = 4'd1,
    GC_INTERRUPT  = 4'd2,
    GC_INI_DONE   = 4'd3,
    GC_MOVE_START = 4'd4,
    GC_ERASE      = 4'd5,
    GC_FINISH     = 4'd6
  } gc_state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_COPY  = 2'b01,
    OP_ERASE = 2'b10
  } cmd_op_t;

endpackage

// File: rtl/gc_engine_if.sv
// Flash command queue handshake between the GC engine and the flash controller.
interface gc_engine_if #(
  parameter int BLOCK_W = nvm_pkg::BLOCK_W,
  parameter int PAGE_W  = nvm_pkg::PAGE_W
);
  import nvm_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  cmd_op_t            cmd_op;
  logic [BLOCK_W-1:0] cmd_block;
  logic [PAGE_W-1:0]  cmd_page;

  modport master (output cmd_valid, cmd_op, cmd_block, cmd_page, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_block, cmd_page, output cmd_ready);

endinterface

// File: rtl/gc_victim_scan.sv
// Pipelined lowest-valid-count search over the valid-count table.
// Free blocks are skipped; strict less-than keeps the lowest index on ties.
module gc_victim_scan #(
  parameter int BLOCK_W = 10,
  parameter int PAGE_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               restart,
  output logic [BLOCK_W-1:0] vc_addr,
  input  logic [PAGE_W:0]    vc_count,
  input  logic               vc_free,
  output logic               done,
  output logic [BLOCK_W-1:0] best_block,
  output logic [PAGE_W:0]    best_count
);

  localparam logic [PAGE_W:0] BEST_INIT = (PAGE_W+1)'(2**PAGE_W + 1);

  logic [BLOCK_W:0]   addr_q, addr_d;
  logic               cmp_q, cmp_d;
  logic [BLOCK_W-1:0] cmp_blk_q, cmp_blk_d;
  logic [BLOCK_W-1:0] best_block_q, best_block_d;
  logic [PAGE_W:0]    best_count_q, best_count_d;

  always_comb begin
    addr_d       = addr_q;
    cmp_d        = 1'b0;
    cmp_blk_d    = cmp_blk_q;
    best_block_d = best_block_q;
    best_count_d = best_count_q;
    done         = 1'b0;
    if (restart) begin
      addr_d       = '0;
      best_block_d = '0;
      best_count_d = BEST_INIT;
    end else if (start) begin
      // addr_q top bit marks the extra cycle that only drains the last compare
      if (!addr_q[BLOCK_W]) begin
        addr_d    = addr_q + (BLOCK_W+1)'(1);
        cmp_d     = 1'b1;
        cmp_blk_d = addr_q[BLOCK_W-1:0];
      end
      if (cmp_q && !vc_free && (vc_count < best_count_q)) begin
        best_count_d = vc_count;
        best_block_d = cmp_blk_q;
      end
      done = addr_q[BLOCK_W] && cmp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      cmp_q        <= 1'b0;
      cmp_blk_q    <= '0;
      best_block_q <= '0;
      best_count_q <= BEST_INIT;
    end else begin
      addr_q       <= addr_d;
      cmp_q        <= cmp_d;
      cmp_blk_q    <= cmp_blk_d;
      best_block_q <= best_block_d;
      best_count_q <= best_count_d;
    end
  end

  assign vc_addr    = start ? addr_q[BLOCK_W-1:0] : '0;
  assign best_block = best_block_q;
  assign best_count = best_count_q;

endmodule

// File: rtl/gc_engine.sv
// Garbage-collection engine: victim scan, COPY of valid pages, ERASE, host yield.
// Define GC_STATS_EN to add the stat_runs/stat_moves saturating counters.
//
// state         | meaning
// IDLE          | waiting for threshold or force_gc trigger
// INI           | scanning valid-count table for the victim
// INI_DONE      | evaluate scan result, latch victim or fail
// MOVE_START    | read page-valid bitmap, issue COPY per valid page
// ERASE         | ERASE command to flash until accepted
// FINISH        | gc_done pulse
// INTERRUPT     | yielding to host traffic
module gc_engine #(
  parameter int BLOCK_W      = nvm_pkg::BLOCK_W,
  parameter int PAGE_W       = nvm_pkg::PAGE_W,
  parameter int GC_THRESHOLD = nvm_pkg::GC_THRESHOLD
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BLOCK_W:0]   free_blocks,
  input  logic               force_gc,
  input  logic               host_req,
  output logic [BLOCK_W-1:0] vc_addr,
  input  logic [PAGE_W:0]    vc_count,
  input  logic               vc_free,
  output logic [BLOCK_W-1:0] pv_block,
  output logic [PAGE_W-1:0]  pv_page,
  input  logic               pv_valid,
  gc_engine_if.master        cmd_if,
  output logic               gc_busy,
  output logic               gc_done,
  output logic               gc_fail,
  output logic [BLOCK_W-1:0] victim
`ifdef GC_STATS_EN
  ,
  output logic [15:0]        stat_runs,
  output logic [23:0]        stat_moves
`endif
);
  import nvm_pkg::*;

  localparam logic [BLOCK_W:0] THRESH    = (BLOCK_W+1)'(GC_THRESHOLD);
  localparam logic [PAGE_W:0]  PAGE_FULL = (PAGE_W+1)'(2**PAGE_W);

  gc_state_t          state_q, state_d;
  logic [BLOCK_W-1:0] victim_q, victim_d;
  logic [PAGE_W:0]    page_q, page_d;
  logic               rd_pend_q, rd_pend_d;
  logic               cmd_pend_q, cmd_pend_d;
  logic               ret_move_q, ret_move_d;

  logic               scan_start, scan_restart, scan_done;
  logic [BLOCK_W-1:0] scan_best_block;
  logic [PAGE_W:0]    scan_best_count;
  logic [PAGE_W:0]    page_nxt;
  logic               copy_acc;
  logic               move_st;
  cmd_op_t            cmd_op_c;

  assign scan_start   = (state_q == GC_INI);
  assign scan_restart = !((state_q == GC_INI) || (state_q == GC_INI_DONE));

  gc_victim_scan #(.BLOCK_W(BLOCK_W), .PAGE_W(PAGE_W)) u_scan (
    .clk        (CLK),
    .rst        (RST),
    .start      (scan_start),
    .restart    (scan_restart),
    .vc_addr    (vc_addr),
    .vc_count   (vc_count),
    .vc_free    (vc_free),
    .done       (scan_done),
    .best_block (scan_best_block),
    .best_count (scan_best_count)
  );

  assign move_st  = (state_q == GC_MOVE_START);
  assign page_nxt = page_q + (PAGE_W+1)'(1);
  assign copy_acc = move_st && cmd_pend_q && cmd_if.cmd_ready;

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    page_d     = page_q;
    rd_pend_d  = 1'b0;
    cmd_pend_d = cmd_pend_q;
    ret_move_d = ret_move_q;
    gc_fail    = 1'b0;
    gc_done    = 1'b0;
    case (state_q)
      GC_IDLE: begin
        page_d     = '0;
        cmd_pend_d = 1'b0;
        if (((free_blocks < THRESH) || force_gc) && !host_req) state_d = GC_INI;
      end
      GC_INI: begin
        if (host_req) begin
          state_d    = GC_INTERRUPT;
          ret_move_d = 1'b0;
        end else if (scan_done) begin
          state_d = GC_INI_DONE;
        end
      end
      GC_INI_DONE: begin
        if (scan_best_count >= PAGE_FULL) begin
          gc_fail = 1'b1;
          state_d = GC_IDLE;
        end else begin
          victim_d = scan_best_block;
          page_d   = '0;
          state_d  = GC_MOVE_START;
        end
      end
      GC_MOVE_START: begin
        if (cmd_pend_q) begin
          // an offered COPY is held until accepted, host_req or not
          if (cmd_if.cmd_ready) begin
            cmd_pend_d = 1'b0;
            page_d     = page_nxt;
            if (host_req) begin
              state_d    = GC_INTERRUPT;
              ret_move_d = 1'b1;
            end
          end
        end else if (host_req) begin
          state_d    = GC_INTERRUPT;
          ret_move_d = 1'b1;
        end else if (page_q[PAGE_W]) begin
          state_d = GC_ERASE;
        end else if (rd_pend_q) begin
          if (pv_valid) cmd_pend_d = 1'b1;
          else          page_d     = page_nxt;
        end else begin
          rd_pend_d = 1'b1;
        end
      end
      GC_INTERRUPT: begin
        if (!host_req) state_d = ret_move_q ? GC_MOVE_START : GC_INI;
      end
      GC_ERASE: begin
        if (cmd_if.cmd_ready) state_d = GC_FINISH;
      end
      GC_FINISH: begin
        gc_done = 1'b1;
        state_d = GC_IDLE;
      end
      default: state_d = GC_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= GC_IDLE;
      victim_q   <= '0;
      page_q     <= '0;
      rd_pend_q  <= 1'b0;
      cmd_pend_q <= 1'b0;
      ret_move_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      page_q     <= page_d;
      rd_pend_q  <= rd_pend_d;
      cmd_pend_q <= cmd_pend_d;
      ret_move_q <= ret_move_d;
    end
  end

  always_comb begin
    cmd_op_c = OP_NONE;
    if (move_st && cmd_pend_q)    cmd_op_c = OP_COPY;
    else if (state_q == GC_ERASE) cmd_op_c = OP_ERASE;
  end

  assign cmd_if.cmd_valid = (cmd_op_c != OP_NONE);
  assign cmd_if.cmd_op    = cmd_op_c;
  assign cmd_if.cmd_block = (cmd_op_c != OP_NONE) ? victim_q : '0;
  assign cmd_if.cmd_page  = (cmd_op_c == OP_COPY) ? page_q[PAGE_W-1:0] : '0;

  assign pv_block = (move_st && !page_q[PAGE_W]) ? victim_q : '0;
  assign pv_page  = (move_st && !page_q[PAGE_W]) ? page_q[PAGE_W-1:0] : '0;
  assign gc_busy  = (state_q != GC_IDLE);
  assign victim   = victim_q;

`ifdef GC_STATS_EN
  logic [15:0] stat_runs_q, stat_runs_d;
  logic [23:0] stat_moves_q, stat_moves_d;

  always_comb begin
    stat_runs_d  = stat_runs_q;
    stat_moves_d = stat_moves_q;
    if (gc_done && (stat_runs_q != '1))   stat_runs_d  = stat_runs_q + 16'd1;
    if (copy_acc && (stat_moves_q != '1)) stat_moves_d = stat_moves_q + 24'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_runs_q  <= '0;
      stat_moves_q <= '0;
    end else begin
      stat_runs_q  <= stat_runs_d;
      stat_moves_q <= stat_moves_d;
    end
  end

  assign stat_runs  = stat_runs_q;
  assign stat_moves = stat_moves_q;
`else
  logic unused_copy_acc;
  assign unused_copy_acc = copy_acc;
`endif

endmodule

// File: tb/tb_gc_engine.sv
// Directed bench for gc_engine with an 8-block, 4-page geometry.
module tb_gc_engine;

  localparam int BW = 3;
  localparam int PW = 2;
  localparam int TH = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [BW:0]   free_blocks = 4'd8;
  logic          force_gc = 1'b0;
  logic          host_req = 1'b0;
  logic [BW-1:0] vc_addr;
  logic [PW:0]   vc_count;
  logic          vc_free;
  logic [BW-1:0] pv_block;
  logic [PW-1:0] pv_page;
  logic          pv_valid;
  logic          cmd_ready = 1'b0;
  logic          gc_busy, gc_done, gc_fail;
  logic [BW-1:0] victim;
`ifdef GC_STATS_EN
  logic [15:0]   stat_runs;
  logic [23:0]   stat_moves;
`endif

  always #5 CLK = ~CLK;

  gc_engine_if #(.BLOCK_W(BW), .PAGE_W(PW)) cmd_if ();
  assign cmd_if.cmd_ready = cmd_ready;

  gc_engine #(.BLOCK_W(BW), .PAGE_W(PW), .GC_THRESHOLD(TH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .free_blocks (free_blocks),
    .force_gc    (force_gc),
    .host_req    (host_req),
    .vc_addr     (vc_addr),
    .vc_count    (vc_count),
    .vc_free     (vc_free),
    .pv_block    (pv_block),
    .pv_page     (pv_page),
    .pv_valid    (pv_valid),
    .cmd_if      (cmd_if),
    .gc_busy     (gc_busy),
    .gc_done     (gc_done),
    .gc_fail     (gc_fail),
    .victim      (victim)
`ifdef GC_STATS_EN
    ,
    .stat_runs   (stat_runs),
    .stat_moves  (stat_moves)
`endif
  );

  // metadata tables with one-cycle read latency
  logic [PW:0] vc_mem [8];
  logic        vf_mem [8];
  logic [3:0]  pv_mem [8];

  always @(posedge CLK) begin
    vc_count <= vc_mem[vc_addr];
    vc_free  <= vf_mem[vc_addr];
    pv_valid <= pv_mem[pv_block][pv_page];
  end

  int n_copy = 0, n_erase = 0, n_fail = 0, n_cv = 0;
  always @(posedge CLK) begin
    if (cmd_if.cmd_valid) n_cv <= n_cv + 1;
    if (cmd_if.cmd_valid && cmd_ready && cmd_if.cmd_op == 2'b01) n_copy <= n_copy + 1;
    if (cmd_if.cmd_valid && cmd_ready && cmd_if.cmd_op == 2'b10) n_erase <= n_erase + 1;
    if (gc_fail) n_fail <= n_fail + 1;
  end

  wire [21:0] all_out = {vc_addr, pv_block, pv_page, cmd_if.cmd_valid, cmd_if.cmd_op,
                         cmd_if.cmd_block, cmd_if.cmd_page, gc_busy, gc_done, gc_fail, victim};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!cmd_if.cmd_valid && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk({tag, " timeout"}, {31'd0, cmd_if.cmd_valid}, 32'd1);
  endtask

  task automatic accept(input string tag, input logic [1:0] op,
                        input logic [BW-1:0] blk, input logic [PW-1:0] pg);
    wait_valid(tag);
    chk({tag, " fields"}, {cmd_if.cmd_op, cmd_if.cmd_block, cmd_if.cmd_page}, {op, blk, pg});
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
  endtask

  initial begin
    int k, b_copy, b_erase, b_fail, b_cv;
    vc_mem = '{3'd4, 3'd2, 3'd3, 3'd2, 3'd4, 3'd1, 3'd4, 3'd3};
    vf_mem = '{0, 0, 0, 0, 0, 1, 0, 0};
    pv_mem = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000};

    repeat (3) @(negedge CLK);
    chk("reset outputs", {10'd0, all_out}, 32'd0);
`ifdef GC_STATS_EN
    chk("reset stats", {8'd0, stat_moves}, 32'd0);
`endif
    RST = 1'b0;

    // trigger boundaries: free_blocks == threshold, host_req veto, unsigned compare
    free_blocks = 4'd2;
    repeat (2) @(negedge CLK);
    chk("no trigger at threshold", {31'd0, gc_busy}, 32'd0);
    free_blocks = 4'd15;
    repeat (2) @(negedge CLK);
    chk("no trigger at 15 unsigned", {31'd0, gc_busy}, 32'd0);
    free_blocks = 4'd1;
    host_req    = 1'b1;
    repeat (2) @(negedge CLK);
    chk("host_req blocks start", {31'd0, gc_busy}, 32'd0);

    // scenario 1: victim 1, COPY pages 0 and 3, ERASE block 1
    b_copy = n_copy; b_erase = n_erase;
    host_req = 1'b0;
    @(negedge CLK);
    chk("s1 busy", {31'd0, gc_busy}, 32'd1);
    chk("s1 scan addr0", {29'd0, vc_addr}, 32'd0);
    free_blocks = 4'd8;
    @(negedge CLK);
    chk("s1 scan addr1", {29'd0, vc_addr}, 32'd1);
    wait_valid("s1 copy0");
    chk("s1 victim", {29'd0, victim}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s1 hold %0d", i),
          {cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_block, cmd_if.cmd_page},
          {1'b1, 2'b01, 3'd1, 2'd0});
      @(negedge CLK);
    end
    accept("s1 copy0", 2'b01, 3'd1, 2'd0);
    chk("s1 one copy accepted", n_copy - b_copy, 32'd1);
    accept("s1 copy3", 2'b01, 3'd1, 2'd3);
    accept("s1 erase", 2'b10, 3'd1, 2'd0);
    chk("s1 gc_done pulse", {31'd0, gc_done}, 32'd1);
    @(negedge CLK);
    chk("s1 done/busy low", {30'd0, gc_done, gc_busy}, 32'd0);
    chk("s1 copy count", n_copy - b_copy, 32'd2);
    chk("s1 erase count", n_erase - b_erase, 32'd1);
`ifdef GC_STATS_EN
    chk("stat_runs", {16'd0, stat_runs}, 32'd1);
    chk("stat_moves", {8'd0, stat_moves}, 32'd2);
`endif

    // scenario 2: every block full, forced run must fail without commands
    for (int i = 0; i < 8; i++) begin
      vc_mem[i] = 3'd4;
      vf_mem[i] = 1'b0;
    end
    b_fail = n_fail; b_cv = n_cv;
    force_gc = 1'b1;
    @(negedge CLK);
    force_gc = 1'b0;
    k = 1;
    while (!gc_fail && k < 40) begin
      @(negedge CLK);
      k++;
    end
    chk("s2 fail latency", k, 32'd10);
    @(negedge CLK);
    chk("s2 idle after fail", {31'd0, gc_busy}, 32'd0);
    chk("s2 one fail pulse", n_fail - b_fail, 32'd1);
    chk("s2 no cmd_valid", n_cv - b_cv, 32'd0);
    chk("s2 victim kept", {29'd0, victim}, 32'd1);

    // scenario 3: host interrupt mid-scan, victim 6
    vc_mem = '{3'd4, 3'd3, 3'd2, 3'd4, 3'd4, 3'd1, 3'd1, 3'd3};
    vf_mem = '{0, 0, 0, 0, 0, 1, 0, 0};
    b_copy = n_copy;
    force_gc = 1'b1;
    @(negedge CLK);
    force_gc = 1'b0;
    k = 0;
    while (vc_addr != 3'd4 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("s3 reached block 4", {29'd0, vc_addr}, 32'd4);
    host_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("s3 interrupt %0d", i), {27'd0, gc_busy, cmd_if.cmd_valid, vc_addr},
          {27'd0, 1'b1, 1'b0, 3'd0});
    end
    host_req = 1'b0;
    @(negedge CLK);
    chk("s3 rescan addr0", {29'd0, vc_addr}, 32'd0);
    @(negedge CLK);
    chk("s3 rescan addr1", {29'd0, vc_addr}, 32'd1);
    wait_valid("s3 copy1");
    chk("s3 victim", {29'd0, victim}, 32'd6);
    chk("s3 copy1 fields", {cmd_if.cmd_op, cmd_if.cmd_block, cmd_if.cmd_page},
        {2'b01, 3'd6, 2'd1});

    // scenario 4: host_req together with cmd_ready on COPY page 1
    host_req  = 1'b1;
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
    chk("s4 copy accepted", n_copy - b_copy, 32'd1);
    chk("s4 interrupt", {30'd0, gc_busy, cmd_if.cmd_valid}, 32'd2);
    repeat (2) @(negedge CLK);
    host_req = 1'b0;
    @(negedge CLK);
    chk("s4 resume read page2", {27'd0, pv_block, pv_page}, {27'd0, 3'd6, 2'd2});
    accept("s4 copy2", 2'b01, 3'd6, 2'd2);
    chk("s4 no duplicate copy", n_copy - b_copy, 32'd2);

    // scenario 5: reset during ERASE wait
    wait_valid("s5 erase");
    chk("s5 erase fields", {cmd_if.cmd_op, cmd_if.cmd_block, cmd_if.cmd_page},
        {2'b10, 3'd6, 2'd0});
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("s5 outputs after RST", {10'd0, all_out}, 32'd0);
`ifdef GC_STATS_EN
    chk("s5 stats after RST", {8'd0, stat_moves}, 32'd0);
`endif
    RST = 1'b0;
    b_cv = n_cv;
    repeat (4) @(negedge CLK);
    chk("s5 stays idle", {30'd0, gc_busy, cmd_if.cmd_valid}, 32'd0);
    chk("s5 no reissue", n_cv - b_cv, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
